// File: rtl/seq_mul_param.sv
// Sequential shift-add multiplier with optional two's-complement and accumulate modes.
// Iterations track the magnitude of the multiplier, so small multipliers finish early.
module seq_mul_param #(
  parameter int WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic                 acc_en,
  input  logic [WIDTH-1:0]     word1,
  input  logic [WIDTH-1:0]     word2,
  output logic [2*WIDTH-1:0]   product,
  output logic                 ready,
  output logic                 done
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   product_q, product_d;
  logic            done_q, done_d;
  logic            neg_q, neg_d;
  logic            acc_q, acc_d;
  logic [PW-1:0]   mag_a_q, mag_a_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic [PW-1:0]   work_q, work_d;

  logic [WIDTH-1:0] abs1, abs2;
  logic             zero_op;

  // The most negative value negates to itself, which reads correctly as an unsigned magnitude.
  always_comb begin
    abs1    = (signed_mode && word1[WIDTH-1]) ? ((~word1) + WIDTH'(1)) : word1;
    abs2    = (signed_mode && word2[WIDTH-1]) ? ((~word2) + WIDTH'(1)) : word2;
    zero_op = (word1 == '0) || (word2 == '0);
  end

  always_comb begin
    state_d   = state_q;
    product_d = product_q;
    done_d    = 1'b0;
    neg_d     = neg_q;
    acc_d     = acc_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    work_d    = work_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (zero_op) begin
            product_d = acc_en ? product_q : '0;
            done_d    = 1'b1;
          end else begin
            neg_d   = signed_mode & (word1[WIDTH-1] ^ word2[WIDTH-1]);
            mag_a_d = PW'(abs1);
            mag_b_d = abs2;
            work_d  = '0;
            acc_d   = acc_en;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (mag_b_q[0]) work_d = work_q + mag_a_q;
        mag_a_d = mag_a_q << 1;
        mag_b_d = mag_b_q >> 1;
        if ((mag_b_q >> 1) == '0) state_d = S_FIX;
      end
      S_FIX: begin
        // Sign correction and accumulation both wrap modulo 2^(2*WIDTH).
        product_d = (neg_q ? ((~work_q) + PW'(1)) : work_q) + (acc_q ? product_q : '0);
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      product_q <= '0;
      done_q    <= 1'b0;
      neg_q     <= 1'b0;
      acc_q     <= 1'b0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      work_q    <= '0;
    end else begin
      state_q   <= state_d;
      product_q <= product_d;
      done_q    <= done_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      work_q    <= work_d;
    end
  end

  assign product = product_q;
  assign done    = done_q;
  assign ready   = (state_q == S_IDLE) && !reset;

endmodule

// File: tb/tb_seq_mul_param.sv
// Self-checking bench for seq_mul_param (WIDTH=8): directed test-plan cases plus
// randomized operations, all compared against an arithmetic reference model.
module tb_seq_mul_param;

  logic        clock;
  logic        reset;
  logic        start;
  logic        signed_mode;
  logic        acc_en;
  logic [7:0]  word1;
  logic [7:0]  word2;
  logic [15:0] product;
  logic        ready;
  logic        done;

  int compared;
  int mismatched;
  logic [15:0] model_p;

  seq_mul_param #(.WIDTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .signed_mode (signed_mode),
    .acc_en      (acc_en),
    .word1       (word1),
    .word2       (word2),
    .product     (product),
    .ready       (ready),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One full operation: expectation from plain integer arithmetic, then drive and observe.
  task automatic applyStimulus(input logic [7:0] w1, input logic [7:0] w2,
                               input logic sm, input logic acc, input bit inj_in);
    int a, b, p, mb, n, lat_exp, edges;
    bit inj;
    logic [15:0] exp_p;
    a  = sm ? int'($signed(w1)) : int'(w1);
    b  = sm ? int'($signed(w2)) : int'(w2);
    p  = a * b;
    exp_p = acc ? (model_p + 16'(p)) : 16'(p);
    mb = (b < 0) ? -b : b;
    n  = 0;
    while (mb > 0) begin
      n++;
      mb = mb >> 1;
    end
    lat_exp = (w1 == 8'd0 || w2 == 8'd0) ? 1 : n + 2;
    inj = inj_in && (lat_exp >= 5);

    @(negedge clock);
    word1 = w1; word2 = w2; signed_mode = sm; acc_en = acc; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    word1 = 8'($urandom); word2 = 8'($urandom);
    signed_mode = 1'($urandom); acc_en = 1'($urandom);
    edges = 1;
    checkOutput("ready_after_accept", ready, lat_exp == 1);
    while (!done && edges < 40) begin
      if (inj && edges == 2) begin
        @(negedge clock);
        word1 = 8'($urandom_range(1, 255)); word2 = 8'($urandom_range(1, 255));
        start = 1'b1;
      end
      @(posedge clock);
      #1;
      start = 1'b0;
      edges++;
    end
    checkOutput("latency", edges, lat_exp);
    checkOutput("product", product, exp_p);
    checkOutput("ready_in_done", ready, 1'b1);
    model_p = exp_p;
  endtask

  initial begin
    bit saw_done;
    compared = 0;
    mismatched = 0;
    model_p = '0;
    reset = 1'b1; start = 1'b0; signed_mode = 1'b0; acc_en = 1'b0;
    word1 = '0; word2 = '0;
    #1;
    checkOutput("reset_product", product, 16'h0000);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_ready", ready, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("ready_after_reset", ready, 1'b1);

    applyStimulus(8'd13, 8'd11, 1'b0, 1'b0, 1'b0);
    checkOutput("plan_13x11", product, 16'h008F);
    applyStimulus(8'hFD, 8'd5, 1'b1, 1'b0, 1'b0);
    checkOutput("plan_m3x5", product, 16'hFFF1);
    applyStimulus(8'h80, 8'h80, 1'b1, 1'b0, 1'b0);
    checkOutput("plan_signed_corner", product, 16'h4000);
    applyStimulus(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
    checkOutput("plan_unsigned_corner", product, 16'h4000);
    applyStimulus(8'd0, 8'd200, 1'b0, 1'b1, 1'b0);
    checkOutput("plan_zero_acc", product, 16'h4000);
    applyStimulus(8'd0, 8'd200, 1'b0, 1'b0, 1'b0);
    checkOutput("plan_zero", product, 16'h0000);
    applyStimulus(8'd10, 8'd10, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'd3, 8'd4, 1'b0, 1'b1, 1'b0);
    checkOutput("plan_acc_112", product, 16'd112);
    applyStimulus(8'd255, 8'd255, 1'b0, 1'b0, 1'b0);
    checkOutput("plan_65025", product, 16'd65025);
    applyStimulus(8'd255, 8'd255, 1'b0, 1'b1, 1'b0);
    checkOutput("plan_wrap", product, 16'hFC02);
    applyStimulus(8'd100, 8'd200, 1'b0, 1'b0, 1'b1);
    checkOutput("plan_ignored_start", product, 16'd20000);

    for (int i = 0; i < 60; i++) begin
      logic [7:0] r1, r2;
      r1 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      r2 = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      applyStimulus(r1, r2, 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
    end

    // Abort a 200*255 operation just before its third RUN edge.
    @(negedge clock);
    word1 = 8'd200; word2 = 8'd255; signed_mode = 1'b0; acc_en = 1'b1; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("abort_product", product, 16'h0000);
    checkOutput("abort_done", done, 1'b0);
    checkOutput("abort_ready", ready, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("abort_ready_release", ready, 1'b1);
    saw_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clock);
      #1;
      if (done) saw_done = 1'b1;
    end
    checkOutput("abort_no_done", saw_done, 1'b0);
    checkOutput("abort_product_held", product, 16'h0000);
    model_p = '0;

    applyStimulus(8'd7, 8'd9, 1'b0, 1'b1, 1'b0);
    checkOutput("post_abort_acc", product, 16'd63);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seq_mul_param.md
# seq_mul_param

Parametrised sequential shift-add multiplier with optional two's-complement mode and accumulate mode. It is the successor to the fixed 4-bit unsigned ASMD multiplier. It sits beside the datapath as a low-area multiply/MAC unit, driven by a start/ready/done handshake. Iteration count scales with the magnitude of the multiplier operand, so small operands finish early.

## Interface
- WIDTH, 8, operand width in bits (≥2); product is 2*WIDTH bits
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request; accepted only when ready=1
- signed_mode  input  1  1: operands are two's complement; 0: unsigned
- acc_en  input  1  1: new product is added to current product register
- word1  input  WIDTH  multiplicand
- word2  input  WIDTH  multiplier
- product  output  2*WIDTH  result register; reset 0; held until next completion
- ready  output  1  (state==S_IDLE) && !reset
- done  output  1  registered one-cycle pulse on completion; reset 0

## Operation
- States: S_IDLE, S_RUN, S_FIX. Reset forces S_IDLE, product=0, done=0, internal registers 0.
- Inputs are sampled only on the clock edge that accepts start (S_IDLE && start). They may change freely afterwards.
- Accept with zero operand (word1==0 or word2==0):
  - product <= acc_en ? product : 0
  - done <= 1
  - stay in S_IDLE
- Accept otherwise:
  - neg <= signed_mode & (word1[MSB] ^ word2[MSB])
  - mag_a <= |word1|, zero-extended to 2*WIDTH
  - mag_b <= |word2| (WIDTH bits)
  - In signed mode, |x| of the most negative value is 2^(WIDTH-1), which fits unsigned.
  - work <= 0; acc_r <= acc_en; go to S_RUN
- S_RUN, every edge:
  - if mag_b[0]: work <= work + mag_a
  - mag_a <= mag_a << 1; mag_b <= mag_b >> 1
  - if (mag_b >> 1)==0: go to S_FIX
- S_FIX, one edge:
  - product <= (neg ? -work : work) + (acc_r ? product : 0), modulo 2^(2*WIDTH)
  - done <= 1; go to S_IDLE
- Accumulation wraps silently. No overflow flag.
- start while not ready is ignored and not queued.
- done is 0 on every edge where no completion occurs.

## Timing
- Let n = bit position of the MSB set in |word2|, plus 1 (1 ≤ n ≤ WIDTH).
- Non-zero operation:
  - accept edge t0, RUN edges t1..tn, FIX edge tn+1
  - product valid and done=1 in the cycle after tn+1
  - latency n+2 edges from accept
- Zero operand: product and done=1 valid in the cycle after the accept edge (latency 1).
- ready=1 in the same cycle as done, so back-to-back start is legal in the done cycle.
- ready is 0 from the cycle after a non-zero accept until the FIX edge completes.
- Reset mid-operation: immediate return to S_IDLE, product=0, done=0. No completion pulse for the aborted operation.
- ready is 0 while reset is asserted.

## Test plan
- Unsigned, WIDTH=8: word1=13, word2=11, acc_en=0 -> done exactly 6 edges after accept, product=143 (16'h008F).
- Signed: word1=8'hFD (-3), word2=5 -> n=3, done after 5 edges, product=16'hFFF1 (-15).
- Signed corner: word1=word2=8'h80 -> n=8, done after 10 edges, product=16'h4000. The same operands unsigned give 16'h4000 (128*128).
- Zero operand: word1=0, word2=200 -> done one cycle after accept, product=0, ready never drops. Repeated with acc_en=1 -> product unchanged.
- Accumulate:
  - 10*10 -> 100
  - then acc_en=1, 3*4 -> 112
  - then unsigned 255*255 with acc_en=0 -> 65025
  - then acc_en=1, 255*255 again -> 16'hFC02 (wrap)
- Control:
  - start pulsed during S_RUN -> ignored; result matches the first operation.
  - reset asserted at RUN edge 3 of a 200*255 operation -> product=0, done never pulses, ready=1 after reset release.
  - back-to-back start in the done cycle -> accepted.
